// File: rtl/stack_responder.sv
// ---------------------------------------------------------------------------
// stack_responder
//   Operand-stack responder for the CPU control unit. The controller sets up
//   push/pop levels and data_in, then raises stack_clk. The rising edge of
//   stack_clk (sampled on clk) starts a command. The command executes one
//   cycle later, and ack pulses for one cycle after that.
//
// Ports
//   clk        system clock (posedge)
//   reset      asynchronous active-high reset
//   flush      synchronous clear (registers only, memory kept)
//   stack_clk  command strobe, rising edge starts a command
//   push/pop   command levels, captured with data_in on the strobe edge
//   data_out   word removed by the last pop or replace
//   tos        current top of stack, 0 when empty
//   ack        one-cycle completion pulse
//   depth      entry count 0..DEPTH
//   empty/full status decoded from depth
//   overflow/underflow/collision  sticky error flags
// ---------------------------------------------------------------------------
module stack_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  stack_clk,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] tos,
    output logic                  ack,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  collision
);

    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

    state_t                  state_q, state_d;
    logic                    strb_q;
    logic                    cpush_q, cpush_d;
    logic                    cpop_q, cpop_d;
    logic [DATA_WIDTH-1:0]   cdata_q, cdata_d;
    logic [ADDR_WIDTH:0]     depth_q, depth_d;
    logic [DATA_WIDTH-1:0]   tos_q, tos_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    col_q, col_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;

    logic                    evt;
    logic                    is_full, is_empty;
    logic [ADDR_WIDTH:0]     dm1, dm2;
    logic [ADDR_WIDTH-1:0]   top_idx, below_idx;

    assign evt      = stack_clk & ~strb_q;
    assign is_full  = (depth_q == (ADDR_WIDTH+1)'(DEPTH));
    assign is_empty = (depth_q == '0);

    // Index arithmetic in depth width; low bits address the memory.
    // below_idx is only used when depth >= 2, so its wrap at depth 1 is harmless.
    assign dm1       = depth_q - (ADDR_WIDTH+1)'(1);
    assign dm2       = depth_q - (ADDR_WIDTH+1)'(2);
    assign top_idx   = dm1[ADDR_WIDTH-1:0];
    assign below_idx = dm2[ADDR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cpush_d = cpush_q;
        cpop_d  = cpop_q;
        cdata_d = cdata_q;
        depth_d = depth_q;
        tos_d   = tos_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        col_d   = col_q;
        we      = 1'b0;
        waddr   = depth_q[ADDR_WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (evt) begin
                    cpush_d = push;
                    cpop_d  = pop;
                    cdata_d = data_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = ACK;
                if (evt) col_d = 1'b1;
                case ({cpush_q, cpop_q})
                    2'b10: begin
                        if (!is_full) begin
                            we      = 1'b1;
                            waddr   = depth_q[ADDR_WIDTH-1:0];
                            depth_d = depth_q + (ADDR_WIDTH+1)'(1);
                            tos_d   = cdata_q;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    2'b01: begin
                        if (!is_empty) begin
                            dout_d  = mem[top_idx];
                            depth_d = dm1;
                            tos_d   = (dm1 == '0) ? '0 : mem[below_idx];
                        end else begin
                            dout_d = '0;
                            unf_d  = 1'b1;
                        end
                    end
                    2'b11: begin
                        if (!is_empty) begin
                            dout_d = mem[top_idx];
                            we     = 1'b1;
                            waddr  = top_idx;
                            tos_d  = cdata_q;
                        end else begin
                            // Replace on an empty stack degrades to a push.
                            we      = 1'b1;
                            waddr   = '0;
                            depth_d = (ADDR_WIDTH+1)'(1);
                            tos_d   = cdata_q;
                            unf_d   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ACK: begin
                state_d = IDLE;
                if (evt) col_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            strb_q  <= 1'b0;
            cpush_q <= 1'b0;
            cpop_q  <= 1'b0;
            cdata_q <= '0;
            depth_q <= '0;
            tos_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            col_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            strb_q  <= 1'b0;
            cpush_q <= 1'b0;
            cpop_q  <= 1'b0;
            cdata_q <= '0;
            depth_q <= '0;
            tos_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            strb_q  <= stack_clk;
            cpush_q <= cpush_d;
            cpop_q  <= cpop_d;
            cdata_q <= cdata_d;
            depth_q <= depth_d;
            tos_q   <= tos_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            col_q   <= col_d;
        end
    end

    // Storage has no reset; flush abandons any in-flight write.
    always_ff @(posedge clk) begin
        if (we && !flush && !reset) mem[waddr] <= cdata_q;
    end

    assign data_out  = dout_q;
    assign tos       = tos_q;
    assign ack       = (state_q == ACK);
    assign depth     = depth_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign collision = col_q;

endmodule

// File: tb/tb_stack_responder.sv
// ---------------------------------------------------------------------------
// tb_stack_responder
//   Directed stimulus with hand-computed expectations. Each command pushes
//   its expected response into a scoreboard queue; a monitor pops and checks
//   on every ack pulse, including the cycle at which the ack appears.
// ---------------------------------------------------------------------------
module tb_stack_responder;

    logic       clk = 1'b0;
    logic       reset, flush, stack_clk, push, pop;
    logic [7:0] data_in, data_out, tos;
    logic       ack, empty, full, overflow, underflow, collision;
    logic [4:0] depth;

    stack_responder #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .stack_clk(stack_clk),
        .push(push), .pop(pop), .data_in(data_in), .data_out(data_out),
        .tos(tos), .ack(ack), .depth(depth), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] tos;
        int         depth;
        logic       ovf;
        logic       unf;
        logic       col;
        int         cyc;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ack_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every ack consumes one expectation.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            exp_t e;
            ack_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_ackcyc"}, cyc, e.cyc);
                chk({e.nm, "_dout"}, data_out, e.dout);
                chk({e.nm, "_tos"}, tos, e.tos);
                chk({e.nm, "_depth"}, depth, e.depth);
                chk({e.nm, "_flags"}, {overflow, underflow}, {e.ovf, e.unf});
                chk({e.nm, "_col"}, collision, e.col);
            end
        end
    end

    task automatic drain(input string nm);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) return;
        end
        chk({nm, "_timeout"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic cmd(input logic p, input logic q, input logic [7:0] d,
                       input logic [7:0] e_dout, input logic [7:0] e_tos, input int e_depth,
                       input logic e_ovf, input logic e_unf, input string nm);
        exp_t e;
        @(negedge clk);
        push = p; pop = q; data_in = d; stack_clk = 1'b1;
        e.dout = e_dout; e.tos = e_tos; e.depth = e_depth;
        e.ovf = e_ovf; e.unf = e_unf; e.col = 1'b0;
        e.cyc = cyc + 2; e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
        stack_clk = 1'b0;
        drain(nm);
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int a0;
        reset = 1'b1; flush = 1'b0; stack_clk = 1'b0;
        push = 1'b0; pop = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", {depth, empty, full, ack}, {5'd0, 1'b1, 1'b0, 1'b0});
        chk("rst_data", {tos, data_out}, 16'h0000);
        chk("rst_flags", {overflow, underflow, collision}, 3'b000);
        @(negedge clk); reset = 1'b0;

        // push three, pop three
        cmd(1, 0, 8'h11, 8'h00, 8'h11, 1, 0, 0, "push11");
        cmd(1, 0, 8'h22, 8'h00, 8'h22, 2, 0, 0, "push22");
        cmd(1, 0, 8'h33, 8'h00, 8'h33, 3, 0, 0, "push33");
        chk("after_push_empty", empty, 1'b0);
        cmd(0, 1, 8'h00, 8'h33, 8'h22, 2, 0, 0, "pop1");
        cmd(0, 1, 8'h00, 8'h22, 8'h11, 1, 0, 0, "pop2");
        cmd(0, 1, 8'h00, 8'h11, 8'h00, 0, 0, 0, "pop3");
        chk("after_pop_empty", empty, 1'b1);

        // pop on empty stack
        cmd(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, "pop_empty");

        // fill to full, then overflow
        do_flush();
        #1 chk("flush_clr", {underflow, depth}, 6'd0);
        for (int i = 0; i < 16; i++)
            cmd(1, 0, 8'(i), 8'h00, 8'(i), i + 1, 0, 0, "fill");
        chk("full_flag", full, 1'b1);
        cmd(1, 0, 8'hAA, 8'h00, 8'h0F, 16, 1, 0, "push_full");
        chk("still_full", {full, depth}, {1'b1, 5'd16});
        cmd(0, 1, 8'h00, 8'h0F, 8'h0E, 15, 1, 0, "pop_after_ovf");

        // replace
        do_flush();
        cmd(1, 0, 8'h11, 8'h00, 8'h11, 1, 0, 0, "r_push11");
        cmd(1, 0, 8'h22, 8'h00, 8'h22, 2, 0, 0, "r_push22");
        cmd(1, 1, 8'h55, 8'h22, 8'h55, 2, 0, 0, "replace");
        cmd(0, 1, 8'h00, 8'h55, 8'h11, 1, 0, 0, "pop_repl");

        // replace on empty stack acts as push plus underflow
        do_flush();
        cmd(1, 1, 8'h77, 8'h00, 8'h77, 1, 0, 1, "replace_empty");

        // collision: second rising edge lands while in ACK
        do_flush();
        a0 = ack_cnt;
        begin
            exp_t e;
            @(negedge clk);
            push = 1'b1; pop = 1'b0; data_in = 8'h44; stack_clk = 1'b1;
            e.dout = 8'h00; e.tos = 8'h44; e.depth = 1;
            e.ovf = 1'b0; e.unf = 1'b0; e.col = 1'b0;
            e.cyc = cyc + 2; e.nm = "coll";
            sb.push_back(e);
            @(negedge clk); stack_clk = 1'b0;
            @(negedge clk); stack_clk = 1'b1;
            @(negedge clk); stack_clk = 1'b0;
            repeat (5) @(negedge clk);
            #1;
        end
        chk("coll_flag", collision, 1'b1);
        chk("coll_ackcnt", ack_cnt - a0, 1);
        chk("coll_depth", depth, 5'd1);

        // flush while the command is in EXEC
        do_flush();
        cmd(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, "fl_pop_empty");
        cmd(1, 0, 8'h11, 8'h00, 8'h11, 1, 0, 1, "fl_push11");
        a0 = ack_cnt;
        @(negedge clk);
        push = 1'b1; pop = 1'b0; data_in = 8'h99; stack_clk = 1'b1;
        @(negedge clk); stack_clk = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("flexec_noack", ack_cnt - a0, 0);
        chk("flexec_depth", {depth, tos}, {5'd0, 8'h00});
        chk("flexec_flags", {overflow, underflow, collision}, 3'b000);

        // async reset while ack is high
        @(negedge clk);
        push = 1'b1; pop = 1'b0; data_in = 8'h66; stack_clk = 1'b1;
        @(negedge clk); stack_clk = 1'b0;
        @(posedge clk); #1;
        chk("rack_ack_hi", {ack, tos}, {1'b1, 8'h66});
        reset = 1'b1;
        #1;
        chk("rack_ack_drop", {ack, tos, depth}, {1'b0, 8'h00, 5'd0});
        @(negedge clk); reset = 1'b0;
        cmd(1, 0, 8'h12, 8'h00, 8'h12, 1, 0, 0, "post_reset_push");

        repeat (3) @(negedge clk);
        chk("sb_empty_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
